// File: rtl/keypad_scan_fifo_if.sv
// keypad_scan_fifo_if: key-event stream from the keypad scanner (valid/ready, head entry)
//   ev_valid  event available at head
//   ev_ready  consumer accepts head when ev_valid & ev_ready
//   ev_code   {press, key index}
interface keypad_scan_fifo_if #(
  parameter int CODE_W = 4
);
  logic              ev_valid;
  logic              ev_ready;
  logic [CODE_W:0]   ev_code;
  modport master(output ev_valid, ev_code, input ev_ready);
  modport slave(input ev_valid, ev_code, output ev_ready);
endinterface

// File: rtl/keypad_scan_fifo.sv
// keypad_scan_fifo: scanned, debounced keypad with press/release event FIFO and direct-select mux
//   clk, rst_n     clock, async active-low reset
//   key_raw        raw key lines (1 = pressed), asynchronous
//   scan_en        run scan pointer and debounce counters
//   sel_in/mux_out synchronised key_raw[sel_in], 0 when out of range
//   key_state      debounced key states
//   fifo_count     events held; overflow sticky drop flag, clr_ovf clears it
//   ev             event stream (master)
module keypad_scan_fifo #(
  parameter int NUM_KEYS       = 12,
  parameter int CODE_W         = 4,
  parameter int SCAN_DIV       = 1,
  parameter int DEBOUNCE       = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int REPORT_RELEASE = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_KEYS-1:0]           key_raw,
  input  logic                          scan_en,
  input  logic [CODE_W-1:0]             sel_in,
  output logic                          mux_out,
  output logic [NUM_KEYS-1:0]           key_state,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clr_ovf,
  keypad_scan_fifo_if.master            ev
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int CW = DEBOUNCE > 1 ? $clog2(DEBOUNCE) : 1;
  localparam int PW = 2 ** CODE_W;
  logic [NUM_KEYS-1:0] key_m, key_s;
  logic [DW-1:0]       div_cnt;
  logic [CODE_W-1:0]   scan_idx;
  logic [CW-1:0]       cnt [NUM_KEYS];
  logic [PW-1:0]       key_pad;
  logic [CW-1:0]       k_cnt;
  logic                k_val, k_st, tick, accept, push, pop, full, wr_en, drop;
  logic [CODE_W:0]     mem [FIFO_DEPTH];
  logic [CODE_W:0]     last_code;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  always_comb begin
    key_pad = '0;
    key_pad[NUM_KEYS-1:0] = key_s;
    k_st = 1'b0;
    k_cnt = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      k_st = scan_idx == CODE_W'(k) ? key_state[k] : k_st;
      k_cnt = scan_idx == CODE_W'(k) ? cnt[k] : k_cnt;
    end
  end
  assign mux_out = key_pad[sel_in];
  assign k_val = key_pad[scan_idx];
  assign tick = scan_en && div_cnt == DW'(SCAN_DIV - 1);
  assign accept = tick && k_val != k_st && k_cnt == CW'(DEBOUNCE - 1);
  assign push = accept && (k_val || REPORT_RELEASE != 0);
  assign full = fifo_count == (AW + 1)'(FIFO_DEPTH);
  assign pop = ev.ev_valid && ev.ev_ready;
  assign wr_en = push && (!full || pop);
  assign drop = push && full && !pop;
  assign ev.ev_valid = fifo_count != '0;
  assign ev.ev_code = ev.ev_valid ? mem[rd_ptr] : last_code;
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {k_val, scan_idx};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_m <= '0;
      key_s <= '0;
      div_cnt <= '0;
      scan_idx <= '0;
      for (int k = 0; k < NUM_KEYS; k++) cnt[k] <= '0;
      key_state <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      overflow <= 1'b0;
      last_code <= '0;
    end else begin
      key_m <= key_raw;
      key_s <= key_m;
      if (scan_en) div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) scan_idx <= scan_idx == CODE_W'(NUM_KEYS - 1) ? '0 : scan_idx + 1'b1;
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (tick && scan_idx == CODE_W'(k)) begin
          cnt[k] <= (key_s[k] == key_state[k] || accept) ? '0 : cnt[k] + 1'b1;
          if (accept) key_state[k] <= key_s[k];
        end
      end
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_code <= mem[rd_ptr];
      end
      fifo_count <= (wr_en && !pop) ? fifo_count + 1'b1 : (!wr_en && pop) ? fifo_count - 1'b1 : fifo_count;
      overflow <= drop ? 1'b1 : clr_ovf ? 1'b0 : overflow;
    end
  end
endmodule
